// File: rtl/final_circuit.sv
// final_circuit: looped-back UART TX/RX (8E1, 16x oversampling) feeding a 4-digit hex-to-7-segment display.
// Define FINAL_CIRCUIT_PARITY_CHECK_EN to make the receiver check parity and drive Rx_PERROR.
module final_circuit #(
    parameter int DIGIT_SLOT = 1024
) (
    input  logic       reset,
    input  logic       clk,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dp,
    input  logic [2:0] baud_select,
    input  logic       Tx_WR,
    input  logic       TX_EN,
    output logic       TX_BUSY,
    input  logic [7:0] Tx_DATA,
    input  logic       RX_EN,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR,
    output logic       Rx_VALID
);
    localparam int SW = $clog2(DIGIT_SLOT + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIGIT_SLOT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_e;

    logic [13:0] period;
    logic        tx_tick, rx_tick, tx_line, rx_line;
    logic        tx_busy_q, tx_busy_d, tx_arm_q, tx_arm_d;
    logic [13:0] tx_div_q, tx_div_d, rx_div_q, rx_div_d;
    logic [3:0]  tx_tick_q, tx_tick_d, tx_bit_q, tx_bit_d;
    logic [10:0] tx_sh_q, tx_sh_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [3:0]  rx_tick_q, rx_tick_d, rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_prev_q, rx_prev_d, par_q, par_d;
    logic        ferr_q, ferr_d, perr_q, perr_d, valid_q, valid_d;
    logic [15:0] disp_q, disp_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]  dig_q, dig_d;
    logic [3:0]  nib;
    logic [6:0]  seg;

    always_comb begin
        case (baud_select)
            3'b000:  period = 14'd10417;
            3'b001:  period = 14'd2604;
            3'b010:  period = 14'd651;
            3'b011:  period = 14'd326;
            3'b100:  period = 14'd163;
            3'b101:  period = 14'd81;
            3'b110:  period = 14'd54;
            default: period = 14'd27;
        endcase
    end

    assign tx_tick = tx_div_q >= period - 14'd1;
    assign rx_tick = rx_div_q >= period - 14'd1;
    assign tx_line = tx_busy_q ? tx_sh_q[0] : 1'b1;
    assign rx_line = tx_line;

    // tx_arm re-arms only after Tx_WR has been seen low, so a held request sends one frame
    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_arm_d  = tx_arm_q | ~Tx_WR;
        tx_div_d  = tx_tick ? 14'd0 : tx_div_q + 14'd1;
        tx_tick_d = tx_tick_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        if (!TX_EN) begin
            tx_busy_d = 1'b0;
        end else if (!tx_busy_q) begin
            if (Tx_WR && tx_arm_q) begin
                tx_busy_d = 1'b1;
                tx_arm_d  = 1'b0;
                tx_div_d  = 14'd0;
                tx_tick_d = 4'd0;
                tx_bit_d  = 4'd0;
                tx_sh_d   = {1'b1, ^Tx_DATA, Tx_DATA, 1'b0};
            end
        end else if (tx_tick) begin
            tx_tick_d = tx_tick_q + 4'd1;
            if (tx_tick_q == 4'd15) begin
                if (tx_bit_q == 4'd10) begin
                    tx_busy_d = 1'b0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                    tx_sh_d  = {1'b1, tx_sh_q[10:1]};
                end
            end
        end
    end

    // rx_bit counts sampled bits after the start bit: 0-7 data, 8 parity, 9 stop
    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_tick ? 14'd0 : rx_div_q + 14'd1;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_prev_d  = rx_line;
        par_d      = par_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        valid_d    = 1'b0;
        disp_d     = disp_q;
        if (!RX_EN) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_line) begin
                        rx_state_d = RX_START;
                        rx_div_d   = 14'd0;
                        rx_tick_d  = 4'd0;
                    end
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd7) begin
                            rx_state_d = rx_line ? RX_IDLE : RX_DATA;
                            rx_tick_d  = 4'd0;
                            rx_bit_d   = 4'd0;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_tick_d = rx_tick_q + 4'd1;
                        if (rx_tick_q == 4'd15) begin
                            rx_bit_d = rx_bit_q + 4'd1;
                            if (rx_bit_q < 4'd8)
                                rx_sh_d = {rx_line, rx_sh_q[7:1]};
`ifdef FINAL_CIRCUIT_PARITY_CHECK_EN
                            if (rx_bit_q == 4'd8)
                                par_d = rx_line ^ (^rx_sh_q);
`else
                            par_d = 1'b0;
`endif
                            if (rx_bit_q == 4'd9) begin
                                rx_state_d = RX_IDLE;
                                ferr_d     = ~rx_line;
                                perr_d     = par_q;
                                valid_d    = rx_line & ~par_q;
                                disp_d     = (rx_line & ~par_q) ? {disp_q[7:0], rx_sh_q} : disp_q;
                            end
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        slot_d = slot_q == SLOT_LAST ? '0 : slot_q + SW'(1);
        dig_d  = slot_q == SLOT_LAST ? dig_q + 2'd1 : dig_q;
        nib    = disp_q[{dig_q, 2'b00} +: 4];
        case (nib)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b0000001;
            default: seg = 7'b0000000;
        endcase
    end

    assign {an3, an2, an1, an0} = ~(4'b0001 << dig_q);
    assign {a, b, c, d, e, f, g} = ~seg;
    assign dp        = 1'b1;
    assign TX_BUSY   = tx_busy_q;
    assign Rx_FERROR = ferr_q;
    assign Rx_PERROR = perr_q;
    assign Rx_VALID  = valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy_q  <= 1'b0;
            tx_arm_q   <= 1'b1;
            tx_div_q   <= '0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '1;
            rx_state_q <= RX_IDLE;
            rx_div_q   <= '0;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_prev_q  <= 1'b1;
            par_q      <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            valid_q    <= 1'b0;
            disp_q     <= 16'hBBBB;
            slot_q     <= '0;
            dig_q      <= '0;
        end else begin
            tx_busy_q  <= tx_busy_d;
            tx_arm_q   <= tx_arm_d;
            tx_div_q   <= tx_div_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_prev_q  <= rx_prev_d;
            par_q      <= par_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            valid_q    <= valid_d;
            disp_q     <= disp_d;
            slot_q     <= slot_d;
            dig_q      <= dig_d;
        end
    end
endmodule

// File: tb/tb_final_circuit.sv
// tb_final_circuit: self-checking bench for final_circuit (loopback frames, display, baud periods, errors, reset).
module tb_final_circuit;
    localparam int SLOT = 4;

    logic       reset, clk;
    logic       an3, an2, an1, an0, a, b, c, d, e, f, g, dp;
    logic [2:0] baud_select;
    logic       Tx_WR, TX_EN, TX_BUSY, RX_EN, Rx_FERROR, Rx_PERROR, Rx_VALID;
    logic [7:0] Tx_DATA;

    int n_cmp = 0, n_bad = 0, valid_cnt = 0, busy_rises = 0;
    logic busy_prev = 1'b0;
    logic [7:0] exp_q[$];

    typedef struct { logic [7:0] data; logic [31:0] disp; } vec_t;
    typedef struct { logic [2:0] sel; int per; } baud_t;
    vec_t  vecs[4];
    baud_t bauds[5];

    final_circuit #(.DIGIT_SLOT(SLOT)) dut (
        .reset(reset), .clk(clk), .an3(an3), .an2(an2), .an1(an1), .an0(an0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
        .baud_select(baud_select), .Tx_WR(Tx_WR), .TX_EN(TX_EN), .TX_BUSY(TX_BUSY),
        .Tx_DATA(Tx_DATA), .RX_EN(RX_EN), .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR),
        .Rx_VALID(Rx_VALID)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 3ms");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [7:0] ch);
        case (ch)
            "0": return ~7'b1111110;
            "1": return ~7'b0110000;
            "2": return ~7'b1101101;
            "3": return ~7'b1111001;
            "4": return ~7'b0110011;
            "5": return ~7'b1011011;
            "6": return ~7'b1011111;
            "7": return ~7'b1110000;
            "8": return ~7'b1111111;
            "9": return ~7'b1111011;
            "-": return ~7'b0000001;
            default: return 7'h7f;
        endcase
    endfunction

    // scoreboard: every Rx_VALID must match the oldest byte still expected
    always @(negedge clk) begin
        if (reset) begin
            busy_prev = 1'b0;
        end else begin
            if (TX_BUSY && !busy_prev) busy_rises++;
            busy_prev = TX_BUSY;
            if (Rx_VALID) begin
                valid_cnt++;
                check("rx_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("rx_byte", dut.disp_q[7:0], exp_q.pop_front());
            end
        end
    end

    task automatic show(input string name, input logic [31:0] s);
        logic [6:0] got[4];
        int idx, prev = -1, run = 0, seen = 0;
        bit ok = 1;
        for (int i = 0; i < 4; i++) got[i] = '0;
        for (int i = 0; i < SLOT * 10; i++) begin
            @(negedge clk);
            case ({an3, an2, an1, an0})
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx < 0) ok = 0;
            else begin
                got[idx] = {a, b, c, d, e, f, g};
                if (idx == prev) run++;
                else begin
                    if (prev >= 0) begin
                        if (idx != (prev + 1) % 4) ok = 0;
                        if (seen > 0 && run != SLOT) ok = 0;
                        seen++;
                    end
                    run = 1;
                    prev = idx;
                end
            end
        end
        check({name, "_mux"}, 32'(ok), 1);
        check({name, "_seg"}, {4'b0, got[3], got[2], got[1], got[0]},
              {4'b0, glyph(s[31:24]), glyph(s[23:16]), glyph(s[15:8]), glyph(s[7:0])});
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (TX_BUSY && n < 6000) begin n++; @(negedge clk); end
        check({name, "_busy_done"}, 32'(TX_BUSY), 0);
    endtask

    task automatic send(input logic [7:0] v, input bit push);
        int n = 0;
        @(negedge clk);
        Tx_DATA = v;
        Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        if (push) exp_q.push_back(v);
        while (TX_BUSY && n < 6000) begin n++; @(negedge clk); end
        check("busy_len", n, 4752);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int v0, r0, n;
        logic [3:0] t0;
        vecs[0] = '{8'hA8, "  -8"};
        vecs[1] = '{8'h88, "-888"};
        vecs[2] = '{8'hC1, "88 1"};
        vecs[3] = '{8'h23, " 123"};
        bauds[0] = '{3'b111, 27};
        bauds[1] = '{3'b110, 54};
        bauds[2] = '{3'b101, 81};
        bauds[3] = '{3'b011, 326};
        bauds[4] = '{3'b000, 10417};

        reset = 1'b1; Tx_WR = 1'b0; TX_EN = 1'b0; RX_EN = 1'b0; Tx_DATA = 8'h00; baud_select = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(TX_BUSY), 0);
        check("rst_flags", {Rx_FERROR, Rx_PERROR, Rx_VALID}, 0);
        check("rst_an", {an3, an2, an1, an0}, 4'b1110);
        check("rst_seg", {a, b, c, d, e, f, g, dp}, 8'hff);
        reset = 1'b0; TX_EN = 1'b1; RX_EN = 1'b1;
        show("blank", "    ");

        foreach (vecs[i]) begin
            send(vecs[i].data, 1);
            show("frame", vecs[i].disp);
            check("frame_flags", {Rx_FERROR, Rx_PERROR}, 0);
        end
        check("valid_count", valid_cnt, 4);

        // request held well past the end of the frame still sends exactly one frame
        r0 = busy_rises; v0 = valid_cnt;
        exp_q.push_back(8'h45);
        Tx_DATA = 8'h45; Tx_WR = 1'b1;
        repeat (4800) @(negedge clk);
        Tx_WR = 1'b0;
        wait_idle("held");
        repeat (100) @(negedge clk);
        check("held_frames", busy_rises - r0, 1);
        check("held_valid", valid_cnt - v0, 1);
        show("held", "2345");

        // stop bit forced low while the receiver samples it
        v0 = valid_cnt;
        Tx_DATA = 8'h37; Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (4400) @(negedge clk);
        force dut.rx_line = 1'b0;
        repeat (300) @(negedge clk);
        release dut.rx_line;
        wait_idle("ferr");
        repeat (100) @(negedge clk);
        check("ferr_flag", 32'(Rx_FERROR), 1);
        check("ferr_perr", 32'(Rx_PERROR), 0);
        check("ferr_valid", valid_cnt - v0, 0);
        show("ferr", "2345");

        // short low pulse is gone by the mid-start sample
        force dut.rx_line = 1'b0;
        repeat (60) @(negedge clk);
        release dut.rx_line;
        repeat (400) @(negedge clk);
        check("glitch_ferr", 32'(Rx_FERROR), 1);
        check("glitch_valid", valid_cnt - v0, 0);

        RX_EN = 1'b0;
        foreach (bauds[i]) begin
            baud_select = bauds[i].sel;
            Tx_DATA = 8'h5A; Tx_WR = 1'b1;
            @(negedge clk);
            Tx_WR = 1'b0;
            n = 0; t0 = dut.tx_tick_q;
            while (dut.tx_tick_q == t0 && n < 20000) begin @(negedge clk); n++; end
            n = 0; t0 = dut.tx_tick_q;
            while (dut.tx_tick_q == t0 && n < 20000) begin @(negedge clk); n++; end
            check("tick_period", n, bauds[i].per);
            TX_EN = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(TX_BUSY), 0);
            check("abort_line", 32'(dut.tx_line), 1);
            TX_EN = 1'b1;
            @(negedge clk);
        end
        baud_select = 3'b111;
        repeat (10) @(negedge clk);
        RX_EN = 1'b1;

        // asynchronous reset in the middle of a frame
        Tx_DATA = 8'h11; Tx_WR = 1'b1;
        @(negedge clk);
        Tx_WR = 1'b0;
        repeat (1000) @(negedge clk);
        check("pre_reset_busy", 32'(TX_BUSY), 1);
        #3 reset = 1'b1;
        #1;
        check("areset_busy", 32'(TX_BUSY), 0);
        check("areset_line", 32'(dut.tx_line), 1);
        check("areset_flags", {Rx_FERROR, Rx_PERROR, Rx_VALID}, 0);
        check("areset_an", {an3, an2, an1, an0}, 4'b1110);
        check("areset_seg", {a, b, c, d, e, f, g, dp}, 8'hff);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send(8'h55, 1);
        show("after_reset", "  55");
        check("after_reset_flags", {Rx_FERROR, Rx_PERROR}, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/final_circuit.md
FINAL_CIRCUIT -- requirements
Module: final_circuit

Interface
REQ-001 Parameter DIGIT_SLOT, default 1024, clocks each display digit stays enabled.
REQ-002 Positional port order SHALL be: reset, clk, an3, an2, an1, an0, a, b, c, d, e, f, g, dp, baud_select, Tx_WR, TX_EN, TX_BUSY, Tx_DATA, RX_EN, Rx_FERROR, Rx_PERROR, Rx_VALID.
REQ-003 clk  input  1  single system clock, 50 MHz, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 an3..an0  output  1 each  digit enables, active-low, an3 leftmost.
REQ-006 a..g  output  1 each  segment drives, active-low.
REQ-007 dp  output  1  decimal point, active-low, held 1 (off).
REQ-008 baud_select  input  3  baud rate select.
REQ-009 Tx_WR  input  1  write request for Tx_DATA.
REQ-010 TX_EN  input  1  transmitter enable.
REQ-011 TX_BUSY  output  1  frame in transmission.
REQ-012 Tx_DATA  input  8  byte to send.
REQ-013 RX_EN  input  1  receiver enable.
REQ-014 Rx_FERROR / Rx_PERROR  output  1 each  framing / parity error of last frame.
REQ-015 Rx_VALID  output  1  one-clock pulse, good byte received.

Function
REQ-016 Block SHALL contain UART transmitter, receiver and 4-digit display driver; TX serial line SHALL loop internally to RX input; idle line level 1.
REQ-017 Oversample tick (16x baud) period in clocks: 000=10417 (300), 001=2604 (1200), 010=651 (4800), 011=326 (9600), 100=163 (19200), 101=81 (38400), 110=54 (57600), 111=27 (115200).
REQ-018 Frame SHALL be 11 bits: start 0, data LSB first, even parity bit, stop 1; each bit 16 ticks.
REQ-019 Tx_WR SHALL be accepted on the first clock it is high with TX_EN=1 and TX_BUSY=0; Tx_DATA latched then; Tx_WR remaining high after acceptance SHALL NOT start a second frame until it has been low for at least one clock.
REQ-020 TX_BUSY SHALL rise the clock after acceptance and fall exactly 11*16 tick periods later; TX tick counter restarts at acceptance.
REQ-021 Tx_WR while busy or TX_EN=0 SHALL be ignored; TX_EN low mid-frame SHALL abort, line to 1, TX_BUSY to 0.
REQ-022 Receiver (RX_EN=1) SHALL detect 1->0 on line, confirm start at tick 8, then sample each following bit at 16-tick intervals.
REQ-023 After sampling stop bit: Rx_FERROR=(stop==0), Rx_PERROR=(parity mismatch); both held until next frame completes; Rx_VALID pulses one clock only if both are 0.
REQ-024 Start bit reading 1 at tick 8 SHALL be discarded as a glitch, no flags changed; RX_EN=0 SHALL hold receiver idle.
REQ-025 On Rx_VALID, display register SHALL shift: an3/an2 digits get previous an1/an0 byte, an1 = new high nibble, an0 = new low nibble.
REQ-026 Nibble glyphs: 0-9 decimal digits, A = '-' (segment g only), B-F = blank.
REQ-027 Display SHALL multiplex one digit at a time, order an0, an1, an2, an3, DIGIT_SLOT clocks each, exactly one anode low.

Reset
REQ-028 Reset SHALL force: TX_BUSY=0, serial line=1, Rx_FERROR=Rx_PERROR=Rx_VALID=0, all counters 0, display register 0xBBBB (all blank), an0 active, a..g=1, dp=1.
REQ-029 Reset mid-frame SHALL abandon both TX and RX frames without flags.

Configuration
REQ-030 Macro FINAL_CIRCUIT_PARITY_CHECK_EN: defined -> Rx_PERROR computed per REQ-023; undefined -> parity bit still sent, receiver ignores it, Rx_PERROR constant 0.

Verification
REQ-031 baud_select=111, send 0xA8 -> TX_BUSY high 4752 clocks, Rx_VALID once, an1 '-', an0 '8'.
REQ-032 Then 0x88, 0xC1, 0x23 -> after each, display shows "-888", "88 1", " 123"; no error flags.
REQ-033 Tx_WR held high 27 clocks -> exactly one frame sent.
REQ-034 Force stop bit 0 on line -> Rx_FERROR=1, no Rx_VALID, display unchanged.
REQ-035 baud_select=000, send 0x55 -> tick period 10417 clocks, display "  55" after reset.
REQ-036 Assert reset mid-frame -> all outputs return to REQ-028 values asynchronously.
